// File: rtl/arm_defs.sv
// Shared definitions for the ARM pipeline: execute opcodes, NZCV bit positions,
// and the branch offset helper.
package arm_defs;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Word offset sign-extended to 30 bits, then turned into a byte offset.
  function automatic logic [31:0] branchOffset(input logic [23:0] imm);
    logic [29:0] wordOff;
    wordOff = {{6{imm[23]}}, imm};
    return {wordOff, 2'b00};
  endfunction

endpackage

// File: rtl/arm_alu.sv
// Combinational ALU for the execute stage. flagMask tells the caller which
// NZCV bits this opcode is allowed to write; unknown opcodes write none.
module arm_alu
  import arm_defs::*;
(
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic [3:0]  exeCmd,
  input  logic        cin,
  output logic [31:0] res,
  output logic [3:0]  nzcv,
  output logic [3:0]  flagMask
);

  logic [32:0] sum33;
  logic        carry;
  logic        ovf;

  // Opcode decode, 33-bit arithmetic and flag generation.
  always_comb begin
    sum33    = '0;
    res      = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    flagMask = 4'b0000;
    case (exeCmd)
      EXE_MOV: begin
        res      = val2;
        flagMask = 4'b1100;
      end
      EXE_MVN: begin
        res      = ~val2;
        flagMask = 4'b1100;
      end
      EXE_ADD, EXE_ADC: begin
        sum33    = {1'b0, val1} + {1'b0, val2}
                   + ((exeCmd == EXE_ADC) ? {32'b0, cin} : 33'b0);
        res      = sum33[31:0];
        carry    = sum33[32];
        ovf      = (val1[31] == val2[31]) && (sum33[31] != val1[31]);
        flagMask = 4'b1111;
      end
      EXE_SUB, EXE_SBC: begin
        sum33    = {1'b0, val1} - {1'b0, val2}
                   - ((exeCmd == EXE_SBC) ? {32'b0, ~cin} : 33'b0);
        res      = sum33[31:0];
        // bit 32 is the borrow; ARM carry is its inverse
        carry    = ~sum33[32];
        ovf      = (val1[31] != val2[31]) && (sum33[31] != val1[31]);
        flagMask = 4'b1111;
      end
      EXE_AND: begin
        res      = val1 & val2;
        flagMask = 4'b1100;
      end
      EXE_ORR: begin
        res      = val1 | val2;
        flagMask = 4'b1100;
      end
      EXE_EOR: begin
        res      = val1 ^ val2;
        flagMask = 4'b1100;
      end
      default: begin
        res      = '0;
        flagMask = 4'b0000;
      end
    endcase
    nzcv[FLAG_N] = res[31];
    nzcv[FLAG_Z] = (res == 32'b0);
    nzcv[FLAG_C] = carry;
    nzcv[FLAG_V] = ovf;
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, NZCV status register, branch target and the EX/MEM
// pipeline register. Branch outputs are combinational and ignore freeze;
// the hazard unit is responsible for stalling around them.
module exe_stage
  import arm_defs::*;
#(
  parameter int              DW       = 32,
  parameter logic [DW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          validIn,
  input  logic [DW-1:0] pcIn,
  input  logic [3:0]    exeCmd,
  input  logic          sUpdate,
  input  logic          b,
  input  logic          memR,
  input  logic          memW,
  input  logic          wbEn,
  input  logic [3:0]    dest,
  input  logic [DW-1:0] val1,
  input  logic [DW-1:0] val2,
  input  logic [DW-1:0] rmStore,
  input  logic [23:0]   signedImm24,
  output logic [3:0]    statusOut,
  output logic          branchTaken,
  output logic [DW-1:0] branchAddr,
  output logic [DW-1:0] aluResOut,
  output logic [DW-1:0] storeValOut,
  output logic [3:0]    destOut,
  output logic          memROut,
  output logic          memWOut,
  output logic          wbEnOut,
  output logic          validOut,
  output logic [DW-1:0] pcOut
);

  logic [3:0]    statusReg;
  logic [DW-1:0] aluRes;
  logic [3:0]    aluNzcv;
  logic [3:0]    aluMask;

  assign statusOut = statusReg;

  arm_alu uAlu (
    .val1     (val1),
    .val2     (val2),
    .exeCmd   (exeCmd),
    .cin      (statusReg[FLAG_C]),
    .res      (aluRes),
    .nzcv     (aluNzcv),
    .flagMask (aluMask)
  );

  assign branchTaken = validIn & b;
  assign branchAddr  = pcIn + branchOffset(signedImm24);

  // Status register: only bits the opcode owns are replaced; the rest hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      statusReg <= 4'b0000;
    end else if (validIn && sUpdate && !freeze) begin
      statusReg <= (statusReg & ~aluMask) | (aluNzcv & aluMask);
    end
  end

  // EX/MEM register: holds on freeze, loads a bubble's controls as zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      aluResOut   <= '0;
      storeValOut <= '0;
      destOut     <= 4'b0;
      memROut     <= 1'b0;
      memWOut     <= 1'b0;
      wbEnOut     <= 1'b0;
      validOut    <= 1'b0;
      pcOut       <= RESET_PC;
    end else if (!freeze) begin
      aluResOut   <= aluRes;
      storeValOut <= rmStore;
      destOut     <= dest;
      memROut     <= validIn & memR;
      memWOut     <= validIn & memW;
      wbEnOut     <= validIn & wbEn;
      validOut    <= validIn;
      pcOut       <= pcIn;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed vectors carry hand-computed results;
// a monitor pops expectations whenever the EX/MEM register loads.
module tb_exe_stage;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_ADC  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SBC  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_ORR  = 4'b0111;
  localparam logic [3:0] OP_EOR  = 4'b1000;
  localparam logic [3:0] OP_MVN  = 4'b1001;
  localparam logic [3:0] OP_BAD  = 4'b1111;

  typedef struct packed {
    logic        valid, s, b, memR, memW, wbEn;
    logic [3:0]  cmd, dest;
    logic [31:0] pc, v1, v2, store;
    logic [23:0] imm;
    logic [31:0] expRes;
    logic [3:0]  expStatus;
    logic        brChk, brTaken;
    logic [31:0] brAddr;
  } vec_t;

  typedef struct packed {
    logic        checkData;
    logic [31:0] res, store, pc;
    logic [3:0]  dest, status;
    logic        memR, memW, wbEn, valid;
  } exp_t;

  logic        clk;
  logic        rst, freeze, validIn, sUpdate, b, memR, memW, wbEn;
  logic [31:0] pcIn, val1, val2, rmStore;
  logic [3:0]  exeCmd, dest;
  logic [23:0] signedImm24;
  logic [3:0]  statusOut, destOut;
  logic        branchTaken, memROut, memWOut, wbEnOut, validOut;
  logic [31:0] branchAddr, aluResOut, storeValOut, pcOut;

  int   checks   = 0;
  int   failures = 0;
  exp_t expQ[$];
  exp_t lastExp;
  exp_t monE;
  logic loadEvt = 1'b0;

  exe_stage #(.DW(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .validIn(validIn), .pcIn(pcIn),
    .exeCmd(exeCmd), .sUpdate(sUpdate), .b(b), .memR(memR), .memW(memW),
    .wbEn(wbEn), .dest(dest), .val1(val1), .val2(val2), .rmStore(rmStore),
    .signedImm24(signedImm24), .statusOut(statusOut), .branchTaken(branchTaken),
    .branchAddr(branchAddr), .aluResOut(aluResOut), .storeValOut(storeValOut),
    .destOut(destOut), .memROut(memROut), .memWOut(memWOut), .wbEnOut(wbEnOut),
    .validOut(validOut), .pcOut(pcOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic vec_t alu(input logic [3:0] cmd, input logic [31:0] a,
                               input logic [31:0] c, input logic s,
                               input logic [31:0] r, input logic [3:0] st);
    vec_t v;
    v           = '0;
    v.valid     = 1'b1;
    v.s         = s;
    v.wbEn      = 1'b1;
    v.cmd       = cmd;
    v.dest      = 4'hA;
    v.pc        = 32'h40;
    v.v1        = a;
    v.v2        = c;
    v.store     = 32'h5A5A_0000 | {28'b0, cmd};
    v.expRes    = r;
    v.expStatus = st;
    return v;
  endfunction

  function automatic exp_t toExp(input vec_t v);
    exp_t e;
    e.checkData = v.valid;
    e.res       = v.expRes;
    e.store     = v.store;
    e.pc        = v.pc;
    e.dest      = v.dest;
    e.status    = v.expStatus;
    e.memR      = v.valid & v.memR;
    e.memW      = v.valid & v.memW;
    e.wbEn      = v.valid & v.wbEn;
    e.valid     = v.valid;
    return e;
  endfunction

  task automatic chkReset(input string tag);
    chk({tag, "_aluRes"}, aluResOut, 32'h0);
    chk({tag, "_store"}, storeValOut, 32'h0);
    chk({tag, "_dest"}, {28'b0, destOut}, 32'h0);
    chk({tag, "_ctrl"}, {28'b0, memROut, memWOut, wbEnOut, validOut}, 32'h0);
    chk({tag, "_pc"}, pcOut, 32'h0);
    chk({tag, "_status"}, {28'b0, statusOut}, 32'h0);
  endtask

  task automatic chkHold(input exp_t e);
    if (e.checkData) chk("hold_aluRes", aluResOut, e.res);
    chk("hold_status", {28'b0, statusOut}, {28'b0, e.status});
    chk("hold_ctrl", {28'b0, memROut, memWOut, wbEnOut, validOut},
        {28'b0, e.memR, e.memW, e.wbEn, e.valid});
    if (e.checkData) chk("hold_dest", {28'b0, destOut}, {28'b0, e.dest});
  endtask

  // Drive one cycle of inputs; expectations are queued only for loading edges.
  task automatic step(input vec_t v, input logic r, input logic f);
    rst = r; freeze = f;
    validIn = v.valid; sUpdate = v.s; b = v.b; memR = v.memR; memW = v.memW;
    wbEn = v.wbEn; exeCmd = v.cmd; dest = v.dest; pcIn = v.pc; val1 = v.v1;
    val2 = v.v2; rmStore = v.store; signedImm24 = v.imm;
    #1;
    if (v.brChk) begin
      chk("branchTaken", {31'b0, branchTaken}, {31'b0, v.brTaken});
      chk("branchAddr", branchAddr, v.brAddr);
    end
    if (r && !f) begin
      lastExp = toExp(v);
      expQ.push_back(lastExp);
    end
    @(posedge clk);
    #1;
    if (r && f) chkHold(lastExp);
  endtask

  // Note whether the EX/MEM register was allowed to load at this edge.
  always @(posedge clk) loadEvt <= rst && !freeze;

  // Monitor: compare the freshly loaded register against the oldest expectation.
  always @(negedge clk) begin
    if (loadEvt) begin
      if (expQ.size() == 0) begin
        chk("unexpected_load", 32'h1, 32'h0);
      end else begin
        monE = expQ.pop_front();
        chk("status", {28'b0, statusOut}, {28'b0, monE.status});
        chk("valid", {31'b0, validOut}, {31'b0, monE.valid});
        chk("wbEn", {31'b0, wbEnOut}, {31'b0, monE.wbEn});
        chk("memR", {31'b0, memROut}, {31'b0, monE.memR});
        chk("memW", {31'b0, memWOut}, {31'b0, monE.memW});
        if (monE.checkData) begin
          chk("aluRes", aluResOut, monE.res);
          chk("dest", {28'b0, destOut}, {28'b0, monE.dest});
          chk("storeVal", storeValOut, monE.store);
          chk("pc", pcOut, monE.pc);
        end
      end
    end
  end

  initial begin
    vec_t idle;
    vec_t v;
    idle = '0;

    step(idle, 1'b0, 1'b0);
    step(idle, 1'b0, 1'b0);
    chkReset("rst0");

    step(idle, 1'b1, 1'b0);
    v = alu(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 4'b1001);
    v.dest = 4'h3; v.pc = 32'h4;
    step(v, 1'b1, 1'b0);
    v = alu(OP_SUB, 32'd5, 32'd5, 1'b1, 32'h0, 4'b0110); v.wbEn = 1'b0;
    step(v, 1'b1, 1'b0);
    v = alu(OP_ADC, 32'd1, 32'd2, 1'b0, 32'd4, 4'b0110); v.dest = 4'h4;
    step(v, 1'b1, 1'b0);
    step(alu(OP_ADD, 32'd1, 32'd1, 1'b1, 32'd2, 4'b0000), 1'b1, 1'b0);
    step(alu(OP_SBC, 32'd5, 32'd3, 1'b0, 32'd1, 4'b0000), 1'b1, 1'b0);
    step(alu(OP_SBC, 32'd5, 32'd3, 1'b1, 32'd1, 4'b0010), 1'b1, 1'b0);
    step(alu(OP_ADC, 32'd1, 32'd2, 1'b0, 32'd4, 4'b0010), 1'b1, 1'b0);
    step(alu(OP_EOR, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'hFFFF_FFFF, 4'b1010), 1'b1, 1'b0);
    step(alu(OP_MVN, 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0, 4'b0110), 1'b1, 1'b0);
    step(alu(OP_SUB, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 4'b1000), 1'b1, 1'b0);
    step(alu(OP_SUB, 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 4'b0011), 1'b1, 1'b0);
    step(alu(OP_ORR, 32'hF0, 32'h0F, 1'b1, 32'hFF, 4'b0011), 1'b1, 1'b0);
    step(alu(OP_AND, 32'hF0, 32'h0F, 1'b1, 32'h0, 4'b0111), 1'b1, 1'b0);
    v = alu(OP_ADD, 32'h1000, 32'h4, 1'b0, 32'h1004, 4'b0111);
    v.memR = 1'b1; v.dest = 4'h5;
    step(v, 1'b1, 1'b0);
    v = alu(OP_ADD, 32'h2000, 32'h8, 1'b0, 32'h2008, 4'b0111);
    v.memW = 1'b1; v.wbEn = 1'b0; v.store = 32'hDEAD_BEEF;
    step(v, 1'b1, 1'b0);
    step(alu(OP_MOV, 32'h0, 32'h55, 1'b0, 32'h55, 4'b0111), 1'b1, 1'b0);
    step(alu(OP_BAD, 32'h1234, 32'h5678, 1'b1, 32'h0, 4'b0111), 1'b1, 1'b0);
    step(alu(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h0, 4'b0110), 1'b1, 1'b0);
    v = alu(OP_SUB, 32'h0, 32'h1, 1'b1, 32'h0, 4'b0110); v.valid = 1'b0;
    step(v, 1'b1, 1'b0);

    v = alu(OP_ADD, 32'h10, 32'h20, 1'b1, 32'h30, 4'b0000); v.dest = 4'h7;
    step(v, 1'b1, 1'b0);
    v = alu(OP_SUB, 32'h0, 32'h1, 1'b1, 32'h0, 4'b0000); v.dest = 4'h1; v.memW = 1'b1;
    step(v, 1'b1, 1'b1);
    v = alu(OP_MOV, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000); v.dest = 4'h2; v.memR = 1'b1;
    step(v, 1'b1, 1'b1);
    v = alu(OP_EOR, 32'h5, 32'h5, 1'b1, 32'h0, 4'b0000); v.dest = 4'h9; v.pc = 32'h88;
    step(v, 1'b1, 1'b1);
    step(alu(OP_SUB, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 4'b1000), 1'b1, 1'b0);

    v = alu(OP_NONE, 32'h0, 32'h0, 1'b0, 32'h0, 4'b1000);
    v.wbEn = 1'b0; v.b = 1'b1; v.pc = 32'h100; v.imm = 24'hFFFFFE;
    v.brChk = 1'b1; v.brTaken = 1'b1; v.brAddr = 32'hF8;
    step(v, 1'b1, 1'b0);
    v.valid = 1'b0; v.imm = 24'h000010; v.brTaken = 1'b0; v.brAddr = 32'h140;
    step(v, 1'b1, 1'b0);
    v.valid = 1'b1; v.pc = 32'hFFFF_FFFC; v.imm = 24'h000002;
    v.brTaken = 1'b1; v.brAddr = 32'h4;
    step(v, 1'b1, 1'b0);
    v = alu(OP_SUB, 32'h0, 32'h0, 1'b1, 32'h0, 4'b1000);
    v.b = 1'b1; v.pc = 32'h200; v.imm = 24'h800000;
    v.brChk = 1'b1; v.brTaken = 1'b1; v.brAddr = 32'hFE00_0200;
    step(v, 1'b1, 1'b1);

    v = alu(OP_ADD, 32'd7, 32'd8, 1'b1, 32'd15, 4'b0000); v.memR = 1'b1;
    step(v, 1'b0, 1'b1);
    chkReset("rst1");
    step(alu(OP_SUB, 32'd1, 32'd2, 1'b1, 32'hFFFF_FFFF, 4'b1000), 1'b1, 1'b0);

    @(negedge clk);
    #1;
    chk("queue_drained", expQ.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
